bcd_to_binary: RTL and testbench

- Sequential reverse double-dabble converter that turns a packed 4-digit BCD value into its binary equivalent.
- It is the inverse companion of the binary-to-BCD converter in the display/keypad datapath. It takes operator-entered decimal digits and returns a binary value for the arithmetic core.
- It uses the same start/ready handshake as the forward converter, and flags invalid BCD input and results that exceed the 12-bit binary domain.

---
 rtl/bcd_pkg.sv | 17 +
 rtl/bcd_digit_adjust.sv | 17 +
 rtl/bcd_to_binary.sv | 132 +++++++++++++
 tb/tb_bcd_to_binary.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared definitions for the BCD-to-binary converter: default sizes,
// the converter state encoding and the largest legal decimal digit.
package bcd_pkg;

    localparam int DEF_DIGITS  = 4;
    localparam int DEF_BIN_W   = 14;
    localparam int DEF_LIMIT_W = 12;

    localparam logic [3:0] MAX_DIGIT = 4'd9;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        DONE    = 2'd2
    } state_t;

endpackage

// File: rtl/bcd_digit_adjust.sv
// Per-digit helper for reverse double-dabble: subtracts 3 from a digit
// of 8 or more, and reports whether the digit is not a legal decimal.
module bcd_digit_adjust
    import bcd_pkg::*;
(
    input  logic [3:0] digit,
    output logic [3:0] adjusted,
    output logic       gt9
);

    // A shifted digit of 8+ carried a half-ten in from the digit above.
    assign adjusted = digit[3] ? (digit - 4'd3) : digit;

    // Anything above 9 cannot have come from a keypad entry.
    assign gt9 = (digit > MAX_DIGIT);

endmodule

// File: rtl/bcd_to_binary.sv
// Sequential reverse double-dabble converter. A start request captures a
// packed BCD word; BIN_W shift/adjust steps later the binary result is
// registered and ready rises. Non-decimal nibbles short-cut to DONE with
// invalid set, and results above the downstream LIMIT_W-bit range raise
// overflow.
//
// Handshake: start is sampled on every rising edge but only accepted in
// IDLE or DONE; acceptance clears ready, invalid and overflow. ready then
// stays high, with binary/invalid/overflow valid, until the next accepted
// start. start while converting is ignored.
module bcd_to_binary
    import bcd_pkg::*;
#(
    parameter int DIGITS  = DEF_DIGITS,
    parameter int BIN_W   = DEF_BIN_W,
    parameter int LIMIT_W = DEF_LIMIT_W
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic [4*DIGITS-1:0] bcd,
    output logic [BIN_W-1:0]    binary,
    output logic                ready,
    output logic                invalid,
    output logic                overflow,
    output logic [1:0]          dbg_state
);

    localparam int                DW          = 4 * DIGITS;
    localparam int                CW          = $clog2(BIN_W);
    localparam logic [CW-1:0]     LAST_STEP   = CW'(BIN_W - 1);
    localparam int                LIMIT_MAX_I = (1 << LIMIT_W) - 1;
    localparam logic [BIN_W-1:0]  LIMIT_MAX   = BIN_W'(LIMIT_MAX_I);

    state_t            state;
    state_t            state_nxt;
    logic [DW-1:0]     digits;
    logic [DW-1:0]     digits_sh;
    logic [DW-1:0]     digits_adj;
    logic [DW-1:0]     adj_in;
    logic [BIN_W-1:0]  acc;
    logic [BIN_W-1:0]  acc_sh;
    logic [CW-1:0]     step;
    logic              last_step;
    logic              bad_q;
    logic [DIGITS-1:0] nib_gt9;

    assign dbg_state = state;
    assign last_step = (step == LAST_STEP);

    // One step of the conversion: the whole digit/accumulator word moves
    // right by one bit, the low digit bit entering the accumulator MSB.
    assign {digits_sh, acc_sh} = {digits, acc} >> 1;

    // The adjust units see the shifted digits while converting; otherwise
    // they look at the incoming bcd so the legality check is ready for the
    // capture edge.
    assign adj_in = (state == CONVERT) ? digits_sh : bcd;

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        bcd_digit_adjust u_adjust (
            .digit    (adj_in[4*i +: 4]),
            .adjusted (digits_adj[4*i +: 4]),
            .gt9      (nib_gt9[i])
        );
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // Next-state selection.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = CONVERT;
            CONVERT: if (bad_q || last_step) state_nxt = DONE;
            DONE:    if (start) state_nxt = CONVERT;
            default: state_nxt = IDLE;
        endcase
    end

    // Capture, shift/adjust stepping and result registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            digits   <= '0;
            acc      <= '0;
            step     <= '0;
            bad_q    <= 1'b0;
            binary   <= '0;
            ready    <= 1'b0;
            invalid  <= 1'b0;
            overflow <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        digits   <= bcd;
                        acc      <= '0;
                        step     <= '0;
                        bad_q    <= |nib_gt9;
                        ready    <= 1'b0;
                        invalid  <= 1'b0;
                        overflow <= 1'b0;
                    end
                end
                CONVERT: begin
                    if (bad_q) begin
                        // Illegal digits: report without spending any steps.
                        binary   <= '0;
                        invalid  <= 1'b1;
                        overflow <= 1'b0;
                        ready    <= 1'b1;
                    end else begin
                        digits <= digits_adj;
                        acc    <= acc_sh;
                        step   <= step + CW'(1);
                        if (last_step) begin
                            binary   <= acc_sh;
                            ready    <= 1'b1;
                            overflow <= (acc_sh > LIMIT_MAX);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_to_binary.sv
// Directed bench for bcd_to_binary. Drivers push the expected result and
// the start-edge cycle when a request is accepted; a monitor pops and
// compares on every rising edge of ready.
module tb_bcd_to_binary;
    import bcd_pkg::*;

    localparam int W = 24; // {latency[7:0], invalid, overflow, binary[13:0]}

    logic        clk     = 1'b0;
    logic        reset_n = 1'b0;
    logic        start   = 1'b0;
    logic [15:0] bcd     = '0;
    logic [13:0] binary;
    logic        ready;
    logic        invalid;
    logic        overflow;
    logic [1:0]  dbg_state;

    logic [W-1:0] exp_q[$];
    int           start_q[$];
    int           n_cmp   = 0;
    int           n_bad   = 0;
    int           cyc     = 0;
    logic         ready_d = 1'b0;

    bcd_to_binary dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .bcd       (bcd),
        .binary    (binary),
        .ready     (ready),
        .invalid   (invalid),
        .overflow  (overflow),
        .dbg_state (dbg_state)
    );

    // Clock and edge counter.
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: each new result is checked against the head of the queue.
    always @(negedge clk) begin
        if (!reset_n) begin
            ready_d <= 1'b0;
        end else begin
            ready_d <= ready;
            if (ready && !ready_d) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_result: got bin=%0d inv=%0b ovf=%0b, required no result",
                             binary, invalid, overflow);
                end else begin
                    logic [W-1:0] exp_v;
                    logic [W-1:0] got_v;
                    int           e0;
                    exp_v = exp_q.pop_front();
                    e0    = start_q.pop_front();
                    got_v = {8'(cyc - e0 - 1), invalid, overflow, binary};
                    if (got_v !== exp_v) begin
                        n_bad++;
                        $display("FAIL result: got lat=%0d inv=%0b ovf=%0b bin=%0d, required lat=%0d inv=%0b ovf=%0b bin=%0d",
                                 got_v[23:16], got_v[15], got_v[14], got_v[13:0],
                                 exp_v[23:16], exp_v[15], exp_v[14], exp_v[13:0]);
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", name, got, exp);
        end
    endtask

    task automatic push_exp(input logic [13:0] eb, input logic ei, input logic eo, input int lat);
        exp_q.push_back({8'(lat), ei, eo, eb});
        start_q.push_back(cyc);
    endtask

    // One-cycle start pulse; bcd is scrambled afterwards.
    task automatic issue(input logic [15:0] v, input logic [13:0] eb, input logic ei,
                         input logic eo, input int lat, input bit track);
        @(negedge clk);
        bcd   = v;
        start = 1'b1;
        @(posedge clk);
        if (track) push_exp(eb, ei, eo, lat);
        @(negedge clk);
        start = 1'b0;
        bcd   = 16'($urandom_range(0, 65535));
    endtask

    // Wait (bounded) for all outstanding results, then confirm they hold.
    task automatic wait_done(input logic [13:0] eb);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL timeout: got %0d results outstanding, required 0", exp_q.size());
            exp_q.delete();
            start_q.delete();
        end
        repeat (3) @(negedge clk);
        check("hold_ready", 32'(ready), 32'd1);
        check("hold_binary", 32'(binary), 32'(eb));
    endtask

    initial begin
        // Reset.
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", {28'd0, ready, invalid, overflow, 1'b0}, 32'd0);
        check("reset_binary", 32'(binary), 32'd0);
        check("reset_state", 32'(dbg_state), 32'd0);
        reset_n = 1'b1;

        // Basic and edge values.
        issue(16'h0307, 14'd307,  1'b0, 1'b0, 14, 1'b1); wait_done(14'd307);
        issue(16'h2048, 14'd2048, 1'b0, 1'b0, 14, 1'b1); wait_done(14'd2048);
        issue(16'h0000, 14'd0,    1'b0, 1'b0, 14, 1'b1); wait_done(14'd0);
        issue(16'h4095, 14'd4095, 1'b0, 1'b0, 14, 1'b1); wait_done(14'd4095);

        // Overflow.
        issue(16'h9999, 14'd9999, 1'b0, 1'b1, 14, 1'b1); wait_done(14'd9999);
        issue(16'h4096, 14'd4096, 1'b0, 1'b1, 14, 1'b1); wait_done(14'd4096);

        // Invalid input, then a clean request.
        issue(16'h12A4, 14'd0,    1'b1, 1'b0, 1,  1'b1); wait_done(14'd0);
        issue(16'h1365, 14'd1365, 1'b0, 1'b0, 14, 1'b1); wait_done(14'd1365);

        // Second start pulse at E5 is ignored.
        @(negedge clk);
        bcd   = 16'h0819;
        start = 1'b1;
        @(posedge clk);
        push_exp(14'd819, 1'b0, 1'b0, 14);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        bcd   = 16'h0001;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        wait_done(14'd819);

        // start held through DONE restarts at once.
        @(negedge clk);
        bcd   = 16'h0042;
        start = 1'b1;
        @(posedge clk);
        push_exp(14'd42, 1'b0, 1'b0, 14);
        @(negedge clk);
        bcd = 16'h0100;
        repeat (14) @(posedge clk);
        @(posedge clk);
        push_exp(14'd100, 1'b0, 1'b0, 14);
        @(negedge clk);
        start = 1'b0;
        check("held_ready_one_cycle", 32'(ready), 32'd0);
        wait_done(14'd100);

        // Reset in the middle of a conversion.
        issue(16'h0307, 14'd0, 1'b0, 1'b0, 14, 1'b0);
        repeat (7) @(posedge clk);
        #1 reset_n = 1'b0;
        #1;
        check("midreset_outputs", {28'd0, ready, invalid, overflow, 1'b0}, 32'd0);
        check("midreset_binary", 32'(binary), 32'd0);
        check("midreset_state", 32'(dbg_state), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        issue(16'h0307, 14'd307, 1'b0, 1'b0, 14, 1'b1); wait_done(14'd307);

        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL leftover: got %0d queued, required 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
